// File: rtl/ether_rx_ctrl_if.sv
// ---------------------------------------------------------------------------
// ether_rx_ctrl_if
// Bus bundle between the RMII dibit source, the frame sequencer and the
// downstream CRC/aggregation stages.
//   axiiv/axiid          : dibit stream from the receiver (valid for a whole frame)
//   axiov/axiod          : payload byte strobe and data
//   hdr_valid            : src_mac/ethertype just updated for the current frame
//   src_mac/ethertype    : captured header fields
//   frame_done/frame_ok  : end-of-frame pulse and its grade
//   byte_count           : whole bytes in the last/current frame (saturating)
// Modports: master drives the dibit stream and observes results (source side),
//           slave is the sequencer itself.
// ---------------------------------------------------------------------------
interface ether_rx_ctrl_if;
  logic        axiiv;
  logic [1:0]  axiid;
  logic        axiov;
  logic [7:0]  axiod;
  logic        hdr_valid;
  logic [47:0] src_mac;
  logic [15:0] ethertype;
  logic        frame_done;
  logic        frame_ok;
  logic [10:0] byte_count;

  modport master (
    output axiiv, axiid,
    input  axiov, axiod, hdr_valid, src_mac, ethertype,
    input  frame_done, frame_ok, byte_count
  );

  modport slave (
    input  axiiv, axiid,
    output axiov, axiod, hdr_valid, src_mac, ethertype,
    output frame_done, frame_ok, byte_count
  );
endinterface

// File: rtl/ether_rx_ctrl.sv
// ---------------------------------------------------------------------------
// ether_rx_ctrl
// Frame sequencer behind the RMII receiver. Packs the post-SFD dibit stream
// into bytes, walks the 14-byte Ethernet header, streams payload bytes
// (payload + FCS) and grades each frame on length and byte alignment.
//
// Ports
//   clk  : system clock, at most one dibit per cycle
//   rst  : asynchronous active-high reset
//   bus  : ether_rx_ctrl_if.slave (dibits in; payload, header fields,
//          frame status and byte count out; all outputs registered)
//
// Configuration
//   ETH_MAC_FILTER_EN : when defined, frames whose destination is neither
//                       MY_MAC nor broadcast are consumed in DROP (header
//                       still reported, frame graded bad). When undefined,
//                       every complete header proceeds to PAYLOAD and
//                       MY_MAC does not exist.
// ---------------------------------------------------------------------------
module ether_rx_ctrl #(
  parameter int MIN_BYTES = 64,
  parameter int MAX_BYTES = 1518
`ifdef ETH_MAC_FILTER_EN
  , parameter logic [47:0] MY_MAC = 48'h69695A065491
`endif
) (
  input  logic           clk,
  input  logic           rst,
  ether_rx_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    ST_SYNC    = 3'd0,
    ST_IDLE    = 3'd1,
    ST_HEADER  = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_DROP    = 3'd4
  } state_t;

  localparam logic [10:0] MIN_L    = 11'(MIN_BYTES);
  localparam logic [10:0] MAX_L    = 11'(MAX_BYTES);
  localparam logic [10:0] BCNT_SAT = 11'h7FF;

  // Header bytes kept before the byte-13 edge: all of 0..12 when the
  // destination is compared, otherwise only 6..12 (src + first type byte).
`ifdef ETH_MAC_FILTER_EN
  localparam int HDR_W = 104;
`else
  localparam int HDR_W = 56;
`endif

  state_t            r_state;
  state_t            w_state_nxt;
  logic [1:0]        r_dcnt;
  logic [5:0]        r_sh;
  logic [10:0]       r_bcnt;
  logic [HDR_W-1:0]  r_hdr;

  logic              r_axiov;
  logic [7:0]        r_axiod;
  logic              r_hdr_valid;
  logic [47:0]       r_src_mac;
  logic [15:0]       r_ethertype;
  logic              r_frame_done;
  logic              r_frame_ok;

  logic              w_in_frame;
  logic              w_start;
  logic              w_take;
  logic              w_byte_done;
  logic              w_eof;
  logic              w_ok;
  logic              w_hdr_shift;
  logic              w_hdr_load;
  logic              w_too_long;
  logic              w_dst_ok;
  logic              w_pay_strobe;
  logic [7:0]        w_byte;
  logic [5:0]        w_sh_nxt;
  logic [10:0]       w_bcnt_inc;
  logic [HDR_W+7:0]  w_hdr_full;

  assign w_in_frame  = (r_state == ST_HEADER) || (r_state == ST_PAYLOAD) || (r_state == ST_DROP);
  assign w_start     = (r_state == ST_IDLE) && bus.axiiv;
  assign w_take      = w_in_frame && bus.axiiv;
  assign w_eof       = w_in_frame && !bus.axiiv;
  assign w_byte_done = w_take && (r_dcnt == 2'd3);

  // First dibit is byte bits [1:0]; shifting right leaves {d2,d1,d0} so the
  // fourth dibit completes the byte on top.
  assign w_sh_nxt    = {bus.axiid, r_sh[5:2]};
  assign w_byte      = {bus.axiid, r_sh};

  assign w_bcnt_inc  = (r_bcnt == BCNT_SAT) ? r_bcnt : (r_bcnt + 11'd1);
  assign w_too_long  = (w_bcnt_inc > MAX_L);

  // r_bcnt still holds the index of the byte being completed.
  assign w_hdr_shift = w_byte_done && (r_state == ST_HEADER);
  assign w_hdr_load  = w_hdr_shift && (r_bcnt == 11'd13);
  assign w_hdr_full  = {r_hdr, w_byte};

`ifdef ETH_MAC_FILTER_EN
  assign w_dst_ok = (w_hdr_full[111:64] == MY_MAC) || (w_hdr_full[111:64] == 48'hFFFF_FFFF_FFFF);
`else
  assign w_dst_ok = 1'b1;
`endif

  assign w_ok = (r_state == ST_PAYLOAD) && (r_bcnt >= MIN_L) && (r_bcnt <= MAX_L) &&
                (r_dcnt == 2'd0);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_SYNC;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and payload strobe decision.
  always_comb begin
    w_state_nxt  = r_state;
    w_pay_strobe = 1'b0;
    case (r_state)
      ST_SYNC: begin
        // Never align to a frame already in flight after reset.
        if (!bus.axiiv) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_SYNC;
        end
      end
      ST_IDLE: begin
        if (bus.axiiv) begin
          w_state_nxt = ST_HEADER;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HEADER: begin
        if (!bus.axiiv) begin
          w_state_nxt = ST_IDLE;
        end else if (w_hdr_load) begin
          w_state_nxt = w_dst_ok ? ST_PAYLOAD : ST_DROP;
        end else begin
          w_state_nxt = ST_HEADER;
        end
      end
      ST_PAYLOAD: begin
        if (!bus.axiiv) begin
          w_state_nxt = ST_IDLE;
        end else if (w_byte_done && w_too_long) begin
          // The byte that overruns the limit is swallowed.
          w_state_nxt = ST_DROP;
        end else begin
          w_state_nxt  = ST_PAYLOAD;
          w_pay_strobe = w_byte_done;
        end
      end
      ST_DROP: begin
        if (!bus.axiiv) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DROP;
        end
      end
      default: begin
        w_state_nxt = ST_SYNC;
      end
    endcase
  end

  // Dibit packing, byte counting and header capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dcnt <= 2'd0;
      r_sh   <= 6'd0;
      r_bcnt <= 11'd0;
      r_hdr  <= '0;
    end else begin
      if (w_start) begin
        r_dcnt <= 2'd1;
        r_sh   <= w_sh_nxt;
        r_bcnt <= 11'd0;
      end else if (w_take) begin
        r_dcnt <= r_dcnt + 2'd1;
        r_sh   <= w_sh_nxt;
        if (w_byte_done) begin
          r_bcnt <= w_bcnt_inc;
        end
        if (w_hdr_shift) begin
          r_hdr <= {r_hdr[HDR_W-9:0], w_byte};
        end
      end else if (w_eof) begin
        // Trailing partial dibits are discarded.
        r_dcnt <= 2'd0;
      end
    end
  end

  // Registered outputs: payload, header fields and frame status.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_axiov      <= 1'b0;
      r_axiod      <= 8'd0;
      r_hdr_valid  <= 1'b0;
      r_src_mac    <= 48'd0;
      r_ethertype  <= 16'd0;
      r_frame_done <= 1'b0;
      r_frame_ok   <= 1'b0;
    end else begin
      r_axiov      <= w_pay_strobe;
      r_hdr_valid  <= w_hdr_load;
      r_frame_done <= w_eof;
      r_frame_ok   <= w_eof && w_ok;
      if (w_pay_strobe) begin
        r_axiod <= w_byte;
      end
      if (w_hdr_load) begin
        r_src_mac   <= w_hdr_full[63:16];
        r_ethertype <= w_hdr_full[15:0];
      end
    end
  end

  assign bus.axiov      = r_axiov;
  assign bus.axiod      = r_axiod;
  assign bus.hdr_valid  = r_hdr_valid;
  assign bus.src_mac    = r_src_mac;
  assign bus.ethertype  = r_ethertype;
  assign bus.frame_done = r_frame_done;
  assign bus.frame_ok   = r_frame_ok;
  assign bus.byte_count = r_bcnt;

endmodule

// File: tb/tb_ether_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ether_rx_ctrl
// Directed frames are described as byte arrays; the sender derives from the
// frame rules which payload bytes, header report and frame grade must appear
// and on which cycle, and a monitor compares every output strobe against
// those expectations. Literal checks after each scenario pin the model.
// ---------------------------------------------------------------------------
module tb_ether_rx_ctrl;
  localparam int          MIN_B  = 64;
  localparam int          MAX_B  = 1518;
  localparam logic [47:0] MY_MAC = 48'h69695A065491;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ether_rx_ctrl_if bus();
  ether_rx_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct { int cyc; logic [7:0] d; } pay_t;
  typedef struct { int cyc; logic [47:0] src; logic [15:0] et; } hdr_t;
  typedef struct { int cyc; logic ok; logic [10:0] cnt; } done_t;

  pay_t  pq[$];
  hdr_t  hq[$];
  done_t dq[$];

  int cyc = 0, checks = 0, errors = 0;
  int n_axiov = 0, n_hdr = 0, n_done = 0, n_ok = 0;
  logic        last_ok   = 1'b0;
  logic [7:0]  last_byte = 8'd0;
  logic [47:0] m_src = 48'd0;
  logic [15:0] m_et  = 16'd0;
  logic [7:0]  fb [0:2047];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] d);
    @(posedge clk);
    #1;
    bus.axiiv = v;
    bus.axiid = d;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) drive(1'b0, 2'b00);
  endtask

  task automatic build(input int n, input logic [47:0] dst, input logic [47:0] src,
                       input logic [15:0] et);
    for (int i = 0; i < 6; i++) begin
      fb[i]     = dst[47-8*i -: 8];
      fb[6 + i] = src[47-8*i -: 8];
    end
    fb[12] = et[15:8];
    fb[13] = et[7:0];
    for (int i = 14; i < n; i++) fb[i] = 8'(i - 14);
  endtask

  // Sends fb[0..n-1] plus 'extra' stray dibits, then one idle dibit, queueing
  // every output event the frame rules require at the sampling cycle.
  task automatic send_frame(input int n, input int extra);
    logic [47:0] dst;
    logic        pass;
    int          e;
    dst  = {fb[0], fb[1], fb[2], fb[3], fb[4], fb[5]};
    pass = (n >= 14);
`ifdef ETH_MAC_FILTER_EN
    pass = pass && ((dst == MY_MAC) || (dst == 48'hFFFF_FFFF_FFFF));
`endif
    for (int i = 0; i < n; i++) begin
      for (int j = 0; j < 4; j++) begin
        drive(1'b1, fb[i][2*j +: 2]);
        e = cyc + 1;
        if (j == 3) begin
          if (i == 13) begin
            m_src = {fb[6], fb[7], fb[8], fb[9], fb[10], fb[11]};
            m_et  = {fb[12], fb[13]};
            hq.push_back('{cyc: e, src: m_src, et: m_et});
          end
          if (pass && (i >= 14) && (i < MAX_B)) pq.push_back('{cyc: e, d: fb[i]});
        end
      end
    end
    for (int k = 0; k < extra; k++) drive(1'b1, 2'b01);
    drive(1'b0, 2'b00);
    e = cyc + 1;
    dq.push_back('{cyc: e,
                   ok: pass && (n >= MIN_B) && (n <= MAX_B) && (extra == 0),
                   cnt: (n > 2047) ? 11'd2047 : 11'(n)});
  endtask

  // Cycle counter and output comparison against the queued expectations.
  task automatic monitor();
    pay_t  p;
    hdr_t  h;
    done_t d;
    forever begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (bus.axiov) begin
        n_axiov++;
        last_byte = bus.axiod;
        checks++;
        if (pq.size() == 0) begin
          errors++;
          $display("FAIL axiov: cycle %0d got byte %02h, expected none", cyc, bus.axiod);
        end else begin
          p = pq.pop_front();
          if (p.cyc != cyc || p.d !== bus.axiod) begin
            errors++;
            $display("FAIL axiov: cycle %0d got %02h, expected %02h at cycle %0d",
                     cyc, bus.axiod, p.d, p.cyc);
          end
        end
      end else if (pq.size() > 0 && pq[0].cyc <= cyc) begin
        p = pq.pop_front();
        checks++;
        errors++;
        $display("FAIL axiov missing: cycle %0d got none, expected %02h", cyc, p.d);
      end

      if (bus.hdr_valid) begin
        n_hdr++;
        checks++;
        if (hq.size() == 0) begin
          errors++;
          $display("FAIL hdr_valid: cycle %0d got pulse, expected none", cyc);
        end else begin
          h = hq.pop_front();
          if (h.cyc != cyc || h.src !== bus.src_mac || h.et !== bus.ethertype) begin
            errors++;
            $display("FAIL hdr_valid: cycle %0d got %012h/%04h, expected %012h/%04h at cycle %0d",
                     cyc, bus.src_mac, bus.ethertype, h.src, h.et, h.cyc);
          end
        end
      end else if (hq.size() > 0 && hq[0].cyc <= cyc) begin
        h = hq.pop_front();
        checks++;
        errors++;
        $display("FAIL hdr_valid missing: cycle %0d expected %012h", cyc, h.src);
      end

      if (bus.frame_done) begin
        n_done++;
        last_ok = bus.frame_ok;
        if (bus.frame_ok) n_ok++;
        checks++;
        if (dq.size() == 0) begin
          errors++;
          $display("FAIL frame_done: cycle %0d got pulse, expected none", cyc);
        end else begin
          d = dq.pop_front();
          if (d.cyc != cyc || d.ok !== bus.frame_ok || d.cnt !== bus.byte_count ||
              m_src !== bus.src_mac || m_et !== bus.ethertype) begin
            errors++;
            $display("FAIL frame_done: cycle %0d got ok=%0b cnt=%0d src=%012h type=%04h, expected ok=%0b cnt=%0d src=%012h type=%04h at cycle %0d",
                     cyc, bus.frame_ok, bus.byte_count, bus.src_mac, bus.ethertype,
                     d.ok, d.cnt, m_src, m_et, d.cyc);
          end
        end
      end else if (dq.size() > 0 && dq[0].cyc <= cyc) begin
        d = dq.pop_front();
        checks++;
        errors++;
        $display("FAIL frame_done missing: cycle %0d expected ok=%0b", cyc, d.ok);
      end
    end
  endtask

  int a0, h0, d0, k0;

  initial begin
    bus.axiiv = 1'b0;
    bus.axiid = 2'b00;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst axiov",      64'(bus.axiov),      64'd0);
    chk("rst axiod",      64'(bus.axiod),      64'd0);
    chk("rst hdr_valid",  64'(bus.hdr_valid),  64'd0);
    chk("rst src_mac",    64'(bus.src_mac),    64'd0);
    chk("rst ethertype",  64'(bus.ethertype),  64'd0);
    chk("rst frame_done", 64'(bus.frame_done), 64'd0);
    chk("rst frame_ok",   64'(bus.frame_ok),   64'd0);
    chk("rst byte_count", 64'(bus.byte_count), 64'd0);

    fork
      monitor();
    join_none
    idle(2);

    // Reset pulse mid-frame with the stream continuing: nothing until a gap.
    a0 = n_axiov; h0 = n_hdr; d0 = n_done;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      bus.axiiv = 1'b1;
      bus.axiid = 2'($urandom_range(0, 3));
      rst = (i == 10) || (i == 11);
    end
    idle(3);
    chk("sync axiov count", 64'(n_axiov - a0), 64'd0);
    chk("sync hdr count",   64'(n_hdr - h0),   64'd0);
    chk("sync done count",  64'(n_done - d0),  64'd0);

    // Good broadcast minimum-length frame.
    build(64, 48'hFFFF_FFFF_FFFF, 48'h0A0B0C0D0E0F, 16'h0800);
    a0 = n_axiov; h0 = n_hdr; d0 = n_done;
    send_frame(64, 0);
    idle(2);
    chk("f64 hdr count",   64'(n_hdr - h0),     64'd1);
    chk("f64 axiov count", 64'(n_axiov - a0),   64'd50);
    chk("f64 last byte",   64'(last_byte),      64'h31);
    chk("f64 done count",  64'(n_done - d0),    64'd1);
    chk("f64 frame_ok",    64'(last_ok),        64'd1);
    chk("f64 byte_count",  64'(bus.byte_count), 64'd64);
    chk("f64 src_mac",     64'(bus.src_mac),    64'h0A0B0C0D0E0F);
    chk("f64 ethertype",   64'(bus.ethertype),  64'h0800);

    // Same frame with two trailing dibits.
    a0 = n_axiov;
    send_frame(64, 2);
    idle(2);
    chk("part axiov count", 64'(n_axiov - a0),   64'd50);
    chk("part frame_ok",    64'(last_ok),        64'd0);
    chk("part byte_count",  64'(bus.byte_count), 64'd64);

    // Runts: one past the header, one inside it, one a byte short of minimum.
    build(40, 48'hFFFF_FFFF_FFFF, 48'h0A0B0C0D0E0F, 16'h0800);
    a0 = n_axiov;
    send_frame(40, 0);
    idle(2);
    chk("f40 axiov count", 64'(n_axiov - a0),   64'd26);
    chk("f40 frame_ok",    64'(last_ok),        64'd0);
    chk("f40 byte_count",  64'(bus.byte_count), 64'd40);
    build(10, 48'hFFFF_FFFF_FFFF, 48'h111111111111, 16'h2222);
    a0 = n_axiov; h0 = n_hdr; d0 = n_done;
    send_frame(10, 0);
    idle(2);
    chk("f10 hdr count",   64'(n_hdr - h0),     64'd0);
    chk("f10 axiov count", 64'(n_axiov - a0),   64'd0);
    chk("f10 done count",  64'(n_done - d0),    64'd1);
    chk("f10 frame_ok",    64'(last_ok),        64'd0);
    chk("f10 byte_count",  64'(bus.byte_count), 64'd10);
    chk("f10 src held",    64'(bus.src_mac),    64'h0A0B0C0D0E0F);
    build(63, 48'hFFFF_FFFF_FFFF, 48'h0A0B0C0D0E0F, 16'h0800);
    a0 = n_axiov;
    send_frame(63, 0);
    idle(2);
    chk("f63 axiov count", 64'(n_axiov - a0), 64'd49);
    chk("f63 frame_ok",    64'(last_ok),      64'd0);

    // Length ceiling: exactly max, one over, and well over.
    build(1600, 48'hFFFF_FFFF_FFFF, 48'h0A0B0C0D0E0F, 16'h0800);
    a0 = n_axiov;
    send_frame(1518, 0);
    idle(2);
    chk("f1518 axiov count", 64'(n_axiov - a0), 64'd1504);
    chk("f1518 frame_ok",    64'(last_ok),      64'd1);
    a0 = n_axiov;
    send_frame(1519, 0);
    idle(2);
    chk("f1519 axiov count", 64'(n_axiov - a0), 64'd1504);
    chk("f1519 frame_ok",    64'(last_ok),      64'd0);
    a0 = n_axiov;
    send_frame(1600, 0);
    idle(2);
    chk("f1600 axiov count", 64'(n_axiov - a0),   64'd1504);
    chk("f1600 last byte",   64'(last_byte),      64'hDF);
    chk("f1600 frame_ok",    64'(last_ok),        64'd0);
    chk("f1600 byte_count",  64'(bus.byte_count), 64'd1600);

    // Foreign unicast destination, then two station frames one idle cycle apart.
    build(64, 48'h112233445566, 48'h0A0B0C0D0E0F, 16'h86DD);
    a0 = n_axiov; h0 = n_hdr; k0 = n_ok;
    send_frame(64, 0);
    idle(2);
    chk("foreign hdr count", 64'(n_hdr - h0), 64'd1);
`ifdef ETH_MAC_FILTER_EN
    chk("foreign axiov count", 64'(n_axiov - a0), 64'd0);
    chk("foreign ok count",    64'(n_ok - k0),    64'd0);
`else
    chk("foreign axiov count", 64'(n_axiov - a0), 64'd50);
    chk("foreign ok count",    64'(n_ok - k0),    64'd1);
`endif
    build(64, MY_MAC, 48'h0C0FFEE00001, 16'h0806);
    a0 = n_axiov; d0 = n_done; k0 = n_ok;
    send_frame(64, 0);
    send_frame(64, 0);
    idle(2);
    chk("b2b axiov count", 64'(n_axiov - a0),  64'd100);
    chk("b2b done count",  64'(n_done - d0),   64'd2);
    chk("b2b ok count",    64'(n_ok - k0),     64'd2);
    chk("b2b src_mac",     64'(bus.src_mac),   64'h0C0FFEE00001);
    chk("b2b ethertype",   64'(bus.ethertype), 64'h0806);

    idle(5);
    chk("pending axiov", 64'(pq.size()), 64'd0);
    chk("pending hdr",   64'(hq.size()), 64'd0);
    chk("pending done",  64'(dq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
